uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler and serializer that shares one UART TX line between NUM_REQ byte requesters.
- Consumes the one-cycle baud_tick pulse produced by the team's baud generator. That generator's start input is tied low, so ticks are free-running and evenly spaced.
- On each bit boundary it arbitrates, accepts one byte through a valid/ready handshake and shifts out an 8N1 or 8N2 frame, LSB first.
- Sits between the debug/console clients and the board TX pin.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
DATA_WIDTH, 8, bits per frame payload.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
baud_tick  in  1  one-clock pulse marking each bit boundary.
req_valid  in  NUM_REQ  per-requester byte valid.
req_data  in  NUM_REQ*DATA_WIDTH  requester i's byte occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  out  NUM_REQ  one-hot accept pulse; combinational.
tx  out  1  serial line, registered, idle high.
busy  out  1  high from the accept tick until the tick that ends the last stop bit.
grant_id  out  clog2(NUM_REQ)  index of the requester owning the current frame.
frame_done  out  1  one-cycle pulse on the tick that ends the last stop bit.

Behaviour:
- Reset values: tx=1, busy=0, grant_id=0, frame_done=0, state=IDLE, bit_cnt=0, stop_cnt=0, last_grant=NUM_REQ-1. After reset, requester 0 has highest priority.
- States are IDLE, START, DATA and STOP. All state changes and tx updates happen only on cycles with baud_tick=1. Between ticks, every register holds.
- Accept window: (state==IDLE, or state==STOP with stop_cnt==STOP_BITS-1) and baud_tick=1 and |req_valid.
- Arbitration inside the accept window:
  - Winner is the first asserted req_valid searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle only. Handshake is complete in that cycle.
  - Registered on that edge: shift register <= req_data slice, grant_id <= winner, last_grant <= winner, tx <= 0, busy <= 1, state <= START.
- req_ready rules:
  - Outside the accept window, req_ready is all-zero.
  - A requester whose valid deasserts before the tick is not granted.
  - Data may change freely after the handshake.
- START + tick: tx <= shreg[0], shift right, bit_cnt <= 0, state <= DATA.
- DATA + tick:
  - If bit_cnt==DATA_WIDTH-1: tx <= 1, stop_cnt <= 0, state <= STOP.
  - Otherwise: tx <= next LSB, bit_cnt++.
- STOP + tick:
  - If stop_cnt < STOP_BITS-1: stop_cnt++.
  - Otherwise, frame_done pulses. Then either a new grant is accepted (back-to-back, no idle bit, busy stays 1), or state <= IDLE with busy <= 0.
- Every bit lasts exactly one tick period. Frame length is 1+DATA_WIDTH+STOP_BITS tick periods. Accept-to-first-tx-low latency is one clock.
- Simultaneous requests are resolved strictly by round-robin. A continuously-valid requester waits at most NUM_REQ-1 frames.
- Reset mid-frame: tx returns to 1 on the next edge and the accepted byte is discarded. No req_ready or frame_done is issued during reset.
- A baud_tick coinciding with reset is ignored.
- Counters: bit_cnt has width clog2(DATA_WIDTH). stop_cnt is 1 bit.

Decomposition:
- Shared package/include: state encoding constants and the clog2 function from the existing math include.
- One sub-module, rr_arbiter: combinational. Inputs are req, last_grant and enable. Outputs are one-hot grant and index. Instantiated once.

Test Plan:
- Test harness: baud generator with BAUD_RATE=0, so a tick occurs every 5 clocks.
1. Single byte: req_valid=4'b0001, req_data[7:0]=8'hA5 -> on first tick req_ready=4'b0001 and grant_id=0. Then tx = 0,1,0,1,0,0,1,0,1,1 with each level held 5 clocks; frame_done pulses on the 10th tick; busy=0 afterward.
2. Contention: req_valid=4'b1111 held constant -> grants ordered 0,1,2,3,0; frames back-to-back with no idle bit between stop and start.
3. Round-robin wrap: after a grant to 2, req_valid=4'b0101 -> next grant 0, then 2.
4. STOP_BITS=2 with byte 8'h00 -> tx low for 9 tick periods, then high for 2; frame_done on the 11th tick after accept.
5. Reset mid-frame: reset asserted on the 4th data bit -> tx=1 next edge, busy=0, frame_done never pulses; first grant after reset goes to requester 0.
6. Valid withdrawn before tick: req_valid[1] asserted for 2 clocks between ticks, then dropped -> req_ready stays 0 and tx stays 1.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART TX scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Ceiling log2, minimum useful result for value >= 2.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just above the previous winner.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int   cand;
  logic found;

  // First asserted request at last_grant+1, +2, ... wrapping modulo NUM_REQ.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found               = 1'b1;
        grant[IDX_W'(cand)] = 1'b1;
        idx                 = IDX_W'(cand);
      end
    end
    if (!enable) begin
      grant = '0;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1/8N2 UART TX line between NUM_REQ byte sources.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle high, waiting for a tick with a valid request
// ST_START | start bit (low) on the line
// ST_DATA  | data bit bit_cnt on the line, LSB first
// ST_STOP  | stop bit stop_cnt on the line; last one may chain a new grant
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  localparam int IDX_W     = clog2(NUM_REQ),
  localparam int BIT_W     = clog2(DATA_WIDTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          frame_done
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  stop_last;
  logic                  data_last;
  logic                  accept_win;
  logic                  accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign stop_last  = (stop_cnt_q == 1'(STOP_BITS - 1));
  assign data_last  = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
  // Reset masks the window so no handshake can complete while in reset.
  assign accept_win = !reset && baud_tick &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_last));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (accept_win),
    .grant      (arb_grant),
    .idx        (arb_idx)
  );

  assign accept = |arb_grant;

  // State and datapath registers; every _d holds its value between ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state: advance one bit position per baud tick.
  always_comb begin
    state_d = state_q;
    if (baud_tick) begin
      unique case (state_q)
        ST_IDLE:  if (accept) state_d = ST_START;
        ST_START: state_d = ST_DATA;
        ST_DATA:  if (data_last) state_d = ST_STOP;
        ST_STOP:  if (stop_last) state_d = accept ? ST_START : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and datapath: line level, shifter, counters, grant bookkeeping.
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    if (baud_tick) begin
      unique case (state_q)
        ST_START: begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (data_last) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (!stop_last) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (!accept) begin
            busy_d = 1'b0;
          end
        end
        default: ;
      endcase
      // A grant (from IDLE or chained off the last stop bit) loads a new frame.
      if (accept) begin
        shreg_d      = req_bytes[arb_idx];
        grant_id_d   = arb_idx;
        last_grant_d = arb_idx;
        tx_d         = 1'b0;
        busy_d       = 1'b1;
      end
    end
  end

  assign req_ready  = arb_grant;
  assign frame_done = !reset && baud_tick && (state_q == ST_STOP) && stop_last;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: frame-level model compared every cycle plus directed literal checks.
module tb_uart_tx_sched;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int M_LEN = 1 + DW + 1;
  localparam int HIST  = 8192;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            baud_tick;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            tx, busy, frame_done;
  logic [1:0]      grant_id;

  logic [N-1:0]    req_valid2 = '0;
  logic [N*DW-1:0] req_data2  = '0;
  logic [N-1:0]    req_ready2;
  logic            tx2, busy2, frame_done2;
  logic [1:0]      grant_id2;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int tick_cnt = 0;
  logic chk_en = 1'b0;

  uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .STOP_BITS(1)) u_dut (
    .clock(clock), .reset(reset), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done));

  uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .reset(reset), .baud_tick(baud_tick),
    .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .tx(tx2), .busy(busy2), .grant_id(grant_id2), .frame_done(frame_done2));

  always #5 clock = ~clock;

  // Free-running baud generator: one tick every 5 clocks.
  always @(posedge clock) tick_cnt <= (tick_cnt == 4) ? 0 : tick_cnt + 1;
  assign baud_tick = (tick_cnt == 4);
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level reference model state
  int   m_pos  = -1;
  int   m_gid  = 0;
  int   m_last = N - 1;
  logic m_frame [0:15];

  logic tx_hist  [0:HIST-1];
  logic tx2_hist [0:HIST-1];
  int   acc_cyc[$], acc_id[$], done_cyc[$];
  int   acc2_cyc[$], acc2_id[$], done2_cyc[$];
  logic [N-1:0] hs_last = '0;

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Compare DUT 1 against the model, log events, then advance the model.
  always @(negedge clock) begin
    logic [N-1:0] exp_ready;
    logic         exp_done;
    logic         ending;
    int           w;
    exp_ready = '0;
    exp_done  = 1'b0;
    ending    = 1'b0;
    w         = -1;
    if (!reset && baud_tick) begin
      ending = (m_pos == M_LEN - 1);
      exp_done = ending;
      if (m_pos < 0 || ending)
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    if (chk_en) begin
      check("tx", 32'(tx), 32'((m_pos < 0) ? 1'b1 : m_frame[m_pos]));
      check("busy", 32'(busy), 32'(m_pos >= 0));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("frame_done", 32'(frame_done), 32'(exp_done));
    end
    if (cyc < HIST) tx_hist[cyc] = tx;
    hs_last = req_ready;
    if (|req_ready) begin
      acc_cyc.push_back(cyc);
      acc_id.push_back(onehot_idx(req_ready));
    end
    if (frame_done) done_cyc.push_back(cyc);
    if (reset) begin
      m_pos  = -1;
      m_gid  = 0;
      m_last = N - 1;
    end else if (baud_tick) begin
      if (w >= 0) begin
        m_frame[0] = 1'b0;
        for (int b = 0; b < DW; b++) m_frame[1 + b] = req_data[w*DW + b];
        m_frame[1 + DW] = 1'b1;
        m_pos  = 0;
        m_gid  = w;
        m_last = w;
      end else if (ending) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
    end
  end

  // Event log for the two-stop-bit instance.
  always @(negedge clock) begin
    if (cyc < HIST) tx2_hist[cyc] = tx2;
    if (|req_ready2) begin
      acc2_cyc.push_back(cyc);
      acc2_id.push_back(onehot_idx(req_ready2));
    end
    if (frame_done2) done2_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int b;
    b = 0;
    while (acc_cyc.size() < n && b < budget) begin
      step();
      b++;
    end
    check("accept_timeout", acc_cyc.size() >= n ? 32'(n) : 32'(acc_cyc.size()), 32'(n));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int a, base, dbase;
    int pat [10];
    pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    repeat (3) step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: single byte A5 from requester 0
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    wait_acc(1, 20);
    req_valid = '0;
    if (acc_cyc.size() >= 1) begin
      a = acc_cyc[0];
      check("t1_grant", 32'(acc_id[0]), 32'd0);
      wait_until(a + 53);
      for (int k = 0; k < 10; k++)
        check($sformatf("t1_tx_bit%0d", k), 32'(tx_hist[a + 1 + 5*k]), 32'(pat[k]));
      check("t1_done_count", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() >= 1) check("t1_done_cycle", 32'(done_cyc[0] - a), 32'd50);
      check("t1_busy_after", 32'(busy), 32'd0);
    end

    // 2: all four contending, back-to-back frames
    do_reset();
    base = acc_cyc.size();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom);
    req_valid = 4'b1111;
    wait_acc(base + 5, 300);
    req_valid = '0;
    if (acc_cyc.size() >= base + 5) begin
      for (int k = 0; k < 5; k++)
        check($sformatf("t2_order%0d", k), 32'(acc_id[base + k]), 32'(k % N));
      for (int k = 1; k < 5; k++)
        check($sformatf("t2_gap%0d", k), 32'(acc_cyc[base + k] - acc_cyc[base + k - 1]), 32'd50);
    end
    repeat (60) step();

    // 3: wrap after a grant to requester 2
    do_reset();
    base = acc_cyc.size();
    req_valid = 4'b0100;
    wait_acc(base + 1, 20);
    req_valid = 4'b0101;
    wait_acc(base + 3, 200);
    req_valid = '0;
    if (acc_cyc.size() >= base + 3) begin
      check("t3_first", 32'(acc_id[base]), 32'd2);
      check("t3_second", 32'(acc_id[base + 1]), 32'd0);
      check("t3_third", 32'(acc_id[base + 2]), 32'd2);
    end
    repeat (60) step();

    // 5: reset during data bit 3
    do_reset();
    base  = acc_cyc.size();
    req_valid = 4'b0010;
    wait_acc(base + 1, 20);
    req_valid = '0;
    if (acc_cyc.size() >= base + 1) begin
      a = acc_cyc[base];
      check("t5_grant", 32'(acc_id[base]), 32'd1);
      wait_until(a + 23);
      dbase = done_cyc.size();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_tx_after_reset", 32'(tx), 32'd1);
      check("t5_busy_after_reset", 32'(busy), 32'd0);
      req_valid = 4'b0011;
      wait_acc(base + 2, 20);
      req_valid = '0;
      if (acc_cyc.size() >= base + 2) check("t5_grant_after", 32'(acc_id[base + 1]), 32'd0);
      check("t5_no_done", 32'(done_cyc.size()), 32'(dbase));
    end
    repeat (60) step();

    // 6: valid withdrawn before the tick
    begin
      int b;
      b = 0;
      while (!baud_tick && b < 10) begin
        step();
        b++;
      end
      step();
      base = acc_cyc.size();
      req_valid[1] = 1'b1;
      step();
      step();
      req_valid = '0;
      repeat (10) step();
      check("t6_no_accept", 32'(acc_cyc.size()), 32'(base));
      check("t6_tx_idle", 32'(tx), 32'd1);
    end

    // 4: two stop bits, byte 00, on the second instance
    req_data2[7:0] = 8'h00;
    req_valid2     = 4'b0001;
    begin
      int b;
      b = 0;
      while (acc2_cyc.size() < 1 && b < 20) begin
        step();
        b++;
      end
    end
    req_valid2 = '0;
    check("t4_accept_count", 32'(acc2_cyc.size()), 32'd1);
    if (acc2_cyc.size() >= 1) begin
      a = acc2_cyc[0];
      check("t4_grant", 32'(acc2_id[0]), 32'd0);
      wait_until(a + 58);
      for (int k = 0; k < 11; k++)
        check($sformatf("t4_tx_bit%0d", k), 32'(tx2_hist[a + 1 + 5*k]), (k < 9) ? 32'd0 : 32'd1);
      check("t4_done_count", 32'(done2_cyc.size()), 32'd1);
      if (done2_cyc.size() >= 1) check("t4_done_cycle", 32'(done2_cyc[0] - a), 32'd55);
      check("t4_busy_after", 32'(busy2), 32'd0);
    end

    // Randomized traffic with withdrawals and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs_last[i]) begin
          req_valid[i] = 1'($urandom % 2);
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req_valid[i] && ($urandom % 16 == 0)) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (req_valid[i] && ($urandom % 64 == 0)) begin
          req_valid[i] = 1'b0;
        end
      end
      reset = ($urandom % 1000 == 0);
      step();
    end
    reset = 1'b0;
    req_valid = '0;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
